// File: rtl/ctrl_pipeline_pkg.sv
// ctrl_pipeline_pkg
// Shared constants for the pipelined control unit. It holds the RV32 major
// opcodes, the ALUOp and forwarding-select encodings, and the layout of the
// control bundle that travels from ID/EX down to MEM/WB.
package ctrl_pipeline_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_PASS_B = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEMWB   = 2'b01,
    FWD_EXMEM   = 2'b10
  } fwd_sel_e;

  // Bundle layout, MSB first: EX fields, then MEM {memRead, memWrite, branch},
  // then WB {memToReg, regWrite}. The MEM and WB slices are exactly the
  // mem_vector_o / wb_vector_o orderings.
  typedef struct packed {
    logic    aluSrc;
    alu_op_e aluOp;
    logic    jump;
    logic    memRead;
    logic    memWrite;
    logic    branch;
    logic    memToReg;
    logic    regWrite;
  } ctrl_bundle_t;

  localparam int BUNDLE_W = $bits(ctrl_bundle_t);
  localparam ctrl_bundle_t BUNDLE_ZERO = '0;

endpackage

// File: rtl/ctrl_pipeline_decode.sv
// ctrl_decode
// Pure combinational opcode decode for the ID stage.
// Ports:
//   opcode_i   instr[6:0] of the ID-stage instruction
//   bundle_o   control bundle for the opcode (all zero if unknown)
//   illegal_o  opcode is not one of the supported major opcodes
//   useRs1_o   instruction reads rs1
//   useRs2_o   instruction reads rs2
module ctrl_decode
  import ctrl_pipeline_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output ctrl_bundle_t bundle_o,
  output logic         illegal_o,
  output logic         useRs1_o,
  output logic         useRs2_o
);

  always_comb begin
    bundle_o  = BUNDLE_ZERO;
    illegal_o = 1'b0;
    useRs1_o  = 1'b1;
    useRs2_o  = 1'b0;
    unique case (opcode_i)
      OPC_OP_IMM: begin
        bundle_o.aluSrc   = 1'b1;
        bundle_o.aluOp    = ALU_FUNCT;
        bundle_o.regWrite = 1'b1;
      end
      OPC_R: begin
        bundle_o.aluOp    = ALU_FUNCT;
        bundle_o.regWrite = 1'b1;
        useRs2_o          = 1'b1;
      end
      OPC_LOAD: begin
        bundle_o.aluSrc   = 1'b1;
        bundle_o.aluOp    = ALU_ADD;
        bundle_o.memRead  = 1'b1;
        bundle_o.memToReg = 1'b1;
        bundle_o.regWrite = 1'b1;
      end
      OPC_STORE: begin
        bundle_o.aluSrc   = 1'b1;
        bundle_o.aluOp    = ALU_ADD;
        bundle_o.memWrite = 1'b1;
        useRs2_o          = 1'b1;
      end
      OPC_BRANCH: begin
        bundle_o.aluOp  = ALU_BRANCH;
        bundle_o.branch = 1'b1;
        useRs2_o        = 1'b1;
      end
      OPC_JAL: begin
        bundle_o.jump     = 1'b1;
        bundle_o.regWrite = 1'b1;
        useRs1_o          = 1'b0;
      end
      OPC_JALR: begin
        bundle_o.aluSrc   = 1'b1;
        bundle_o.aluOp    = ALU_ADD;
        bundle_o.jump     = 1'b1;
        bundle_o.regWrite = 1'b1;
      end
      OPC_LUI: begin
        bundle_o.aluSrc   = 1'b1;
        bundle_o.aluOp    = ALU_PASS_B;
        bundle_o.regWrite = 1'b1;
        useRs1_o          = 1'b0;
      end
      OPC_AUIPC: begin
        bundle_o.aluSrc   = 1'b1;
        bundle_o.aluOp    = ALU_ADD;
        bundle_o.regWrite = 1'b1;
        useRs1_o          = 1'b0;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Pipelined control unit: decodes the ID-stage instruction, carries the
// control bundle through ID/EX, EX/MEM and MEM/WB, detects load-use hazards,
// produces EX operand forwarding selects and counts inserted bubbles.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   instr_i, valid_i    ID-stage instruction and its valid flag
//   flush_i, freeze_i   squash the ID instruction / hold every stage
//   stall_o             load-use hazard, hold PC and IF/ID
//   ex_*_o              EX-stage controls (aluSrc, ALUOp, jump)
//   fwd_a_o, fwd_b_o    EX operand sources
//   mem_vector_o        {memRead, memWrite, branch} of the MEM stage
//   wb_vector_o         {memToReg, regWrite} of the WB stage
//   wb_rd_o             WB destination register
//   illegal_o           EX-stage instruction had an unknown opcode
//   bubble_cnt_o        saturating count of hazard bubbles
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              freeze_i,
  output logic              stall_o,
  output logic              ex_aluSrc_o,
  output logic [1:0]        ex_ALUOp_o,
  output logic              ex_jump_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [2:0]        mem_vector_o,
  output logic [1:0]        wb_vector_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic [REG_AW-1:0] idRd, idRs1, idRs2;
  ctrl_bundle_t      decBundle;
  logic              decIllegal, decUseRs1, decUseRs2;
  logic              unusedInstrBits;

  ctrl_bundle_t      idexBundle_q, idexBundle_d;
  logic              idexIllegal_q, idexIllegal_d;
  logic [REG_AW-1:0] idexRd_q, idexRd_d;
  logic [REG_AW-1:0] idexRs1_q, idexRs1_d;
  logic [REG_AW-1:0] idexRs2_q, idexRs2_d;

  logic [2:0]        exmemMem_q;
  logic [1:0]        exmemWb_q;
  logic [REG_AW-1:0] exmemRd_q;
  logic [1:0]        memwbWb_q;
  logic [REG_AW-1:0] memwbRd_q;

  logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
  logic              hazard;
  fwd_sel_e          fwdA, fwdB;

  assign idRd  = instr_i[7  +: REG_AW];
  assign idRs1 = instr_i[15 +: REG_AW];
  assign idRs2 = instr_i[20 +: REG_AW];
  // funct3/funct7 and immediate bits have no role in control decode
  assign unusedInstrBits = ^instr_i;

  ctrl_decode u_decode (
    .opcode_i  (instr_i[6:0]),
    .bundle_o  (decBundle),
    .illegal_o (decIllegal),
    .useRs1_o  (decUseRs1),
    .useRs2_o  (decUseRs2)
  );

  // Load in EX whose result a real ID instruction needs: only register fields
  // the opcode actually reads count, and x0 never creates a dependency.
  assign hazard = idexBundle_q.memRead && (idexRd_q != '0) && valid_i &&
                  ((decUseRs1 && (idRs1 == idexRd_q)) ||
                   (decUseRs2 && (idRs2 == idexRd_q)));
  assign stall_o = hazard;

  // ID/EX load priority: freeze holds, then flush/hazard/invalid give a zero
  // bundle (rd/rs cleared too so a bubble never matches for forwarding),
  // otherwise the decoded instruction. Only a hazard bubble that is not
  // overridden by flush is counted.
  always_comb begin
    idexBundle_d  = idexBundle_q;
    idexIllegal_d = idexIllegal_q;
    idexRd_d      = idexRd_q;
    idexRs1_d     = idexRs1_q;
    idexRs2_d     = idexRs2_q;
    bubbleCnt_d   = bubbleCnt_q;
    if (!freeze_i) begin
      if (flush_i || hazard || !valid_i) begin
        idexBundle_d  = BUNDLE_ZERO;
        idexIllegal_d = 1'b0;
        idexRd_d      = '0;
        idexRs1_d     = '0;
        idexRs2_d     = '0;
      end else begin
        idexBundle_d  = decBundle;
        idexIllegal_d = decIllegal;
        idexRd_d      = idRd;
        idexRs1_d     = idRs1;
        idexRs2_d     = idRs2;
      end
      if (hazard && !flush_i && (bubbleCnt_q != '1)) begin
        bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idexBundle_q  <= BUNDLE_ZERO;
      idexIllegal_q <= 1'b0;
      idexRd_q      <= '0;
      idexRs1_q     <= '0;
      idexRs2_q     <= '0;
      exmemMem_q    <= '0;
      exmemWb_q     <= '0;
      exmemRd_q     <= '0;
      memwbWb_q     <= '0;
      memwbRd_q     <= '0;
      bubbleCnt_q   <= '0;
    end else begin
      idexBundle_q  <= idexBundle_d;
      idexIllegal_q <= idexIllegal_d;
      idexRd_q      <= idexRd_d;
      idexRs1_q     <= idexRs1_d;
      idexRs2_q     <= idexRs2_d;
      bubbleCnt_q   <= bubbleCnt_d;
      if (!freeze_i) begin
        exmemMem_q <= {idexBundle_q.memRead, idexBundle_q.memWrite, idexBundle_q.branch};
        exmemWb_q  <= {idexBundle_q.memToReg, idexBundle_q.regWrite};
        exmemRd_q  <= idexRd_q;
        memwbWb_q  <= exmemWb_q;
        memwbRd_q  <= exmemRd_q;
      end
    end
  end

  // The younger producer (EX/MEM) holds the newest value, so it wins when
  // both later stages write the same register.
  always_comb begin
    fwdA = FWD_REGFILE;
    fwdB = FWD_REGFILE;
    if (exmemWb_q[0] && (exmemRd_q != '0) && (exmemRd_q == idexRs1_q)) begin
      fwdA = FWD_EXMEM;
    end else if (memwbWb_q[0] && (memwbRd_q != '0) && (memwbRd_q == idexRs1_q)) begin
      fwdA = FWD_MEMWB;
    end
    if (exmemWb_q[0] && (exmemRd_q != '0) && (exmemRd_q == idexRs2_q)) begin
      fwdB = FWD_EXMEM;
    end else if (memwbWb_q[0] && (memwbRd_q != '0) && (memwbRd_q == idexRs2_q)) begin
      fwdB = FWD_MEMWB;
    end
  end

  assign ex_aluSrc_o  = idexBundle_q.aluSrc;
  assign ex_ALUOp_o   = idexBundle_q.aluOp;
  assign ex_jump_o    = idexBundle_q.jump;
  assign illegal_o    = idexIllegal_q;
  assign fwd_a_o      = fwdA;
  assign fwd_b_o      = fwdB;
  assign mem_vector_o = exmemMem_q;
  assign wb_vector_o  = memwbWb_q;
  assign wb_rd_o      = memwbRd_q;
  assign bubble_cnt_o = bubbleCnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline
// Scoreboard bench for ctrl_pipeline with a 2-bit bubble counter so that
// saturation is reachable quickly.
module tb_ctrl_pipeline;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  logic              clk_i = 1'b0;
  logic              rst_i, valid_i, flush_i, freeze_i;
  logic [31:0]       instr_i;
  logic              stall_o, ex_aluSrc_o, ex_jump_o, illegal_o;
  logic [1:0]        ex_ALUOp_o, fwd_a_o, fwd_b_o, wb_vector_o;
  logic [2:0]        mem_vector_o;
  logic [REG_AW-1:0] wb_rd_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  ctrl_pipeline #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_i      (instr_i),
    .valid_i      (valid_i),
    .flush_i      (flush_i),
    .freeze_i     (freeze_i),
    .stall_o      (stall_o),
    .ex_aluSrc_o  (ex_aluSrc_o),
    .ex_ALUOp_o   (ex_ALUOp_o),
    .ex_jump_o    (ex_jump_o),
    .fwd_a_o      (fwd_a_o),
    .fwd_b_o      (fwd_b_o),
    .mem_vector_o (mem_vector_o),
    .wb_vector_o  (wb_vector_o),
    .wb_rd_o      (wb_rd_o),
    .illegal_o    (illegal_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         due;
    logic [7:0] val;
    logic [7:0] care;
  } exp_t;

  exp_t exQ[$];
  exp_t memQ[$];
  exp_t wbQ[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, op};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v);
    instr_i = ins;
    valid_i = v;
  endtask

  // ex = {illegal, aluSrc, ALUOp, jump}; results due 1/2/3 edges from now
  task automatic pushExp(input logic [4:0] ex, input logic [2:0] mem,
                         input logic [1:0] wb, input logic [4:0] rd, input logic careRd);
    exQ.push_back('{due: cyc + 1, val: {3'b0, ex}, care: 8'hFF});
    memQ.push_back('{due: cyc + 2, val: {5'b0, mem}, care: 8'hFF});
    wbQ.push_back('{due: cyc + 3, val: {1'b0, wb, rd}, care: careRd ? 8'hFF : 8'hE0});
  endtask

  task automatic step();
    logic [7:0] act;
    exp_t e;
    @(posedge clk_i);
    cyc++;
    #1;
    if (exQ.size() > 0 && exQ[0].due == cyc) begin
      e = exQ.pop_front();
      act = {3'b0, illegal_o, ex_aluSrc_o, ex_ALUOp_o, ex_jump_o};
      compared++;
      if ((act & e.care) !== (e.val & e.care)) begin
        mismatched++;
        $display("[TB] FAIL ex_bundle cyc=%0d got=%b exp=%b", cyc, act, e.val);
      end
    end
    if (memQ.size() > 0 && memQ[0].due == cyc) begin
      e = memQ.pop_front();
      act = {5'b0, mem_vector_o};
      compared++;
      if ((act & e.care) !== (e.val & e.care)) begin
        mismatched++;
        $display("[TB] FAIL mem_vector cyc=%0d got=%b exp=%b", cyc, act, e.val);
      end
    end
    if (wbQ.size() > 0 && wbQ[0].due == cyc) begin
      e = wbQ.pop_front();
      act = {1'b0, wb_vector_o, wb_rd_o};
      compared++;
      if ((act & e.care) !== (e.val & e.care)) begin
        mismatched++;
        $display("[TB] FAIL wb_vector_rd cyc=%0d got=%b exp=%b", cyc, act, e.val);
      end
    end
  endtask

  task automatic idle(input int n, input logic tracked);
    for (int i = 0; i < n; i++) begin
      drive(32'h0, 1'b0);
      if (tracked) pushExp(5'b0, 3'b0, 2'b0, 5'd0, 1'b1);
      step();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; freeze_i = 1'b0;
    drive(32'h0, 1'b0);
    step(); step();
    rst_i = 1'b0;
    step();
    compared++;
    if ({illegal_o, ex_aluSrc_o, ex_ALUOp_o, ex_jump_o, fwd_a_o, fwd_b_o,
         mem_vector_o, wb_vector_o, wb_rd_o, stall_o} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs got=%b%b%b%b%b%b%b%b%b exp=0", illegal_o, ex_aluSrc_o,
               ex_ALUOp_o, ex_jump_o, fwd_a_o, fwd_b_o, mem_vector_o, wb_vector_o, wb_rd_o);
    end
    compared++;
    if (bubble_cnt_o !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_count got=%0d exp=0", bubble_cnt_o);
    end
  endtask

  task automatic test_decode();
    drive(mk(OP_R,     5'd1, 5'd0, 5'd0), 1'b1); pushExp(5'b0_0_10_0, 3'b000, 2'b01, 5'd1, 1'b1); step();
    drive(mk(OP_IMM,   5'd2, 5'd0, 5'd0), 1'b1); pushExp(5'b0_1_10_0, 3'b000, 2'b01, 5'd2, 1'b1); step();
    drive(mk(OP_LOAD,  5'd3, 5'd0, 5'd0), 1'b1); pushExp(5'b0_1_00_0, 3'b100, 2'b11, 5'd3, 1'b1); step();
    drive(mk(OP_STORE, 5'd0, 5'd0, 5'd0), 1'b1); pushExp(5'b0_1_00_0, 3'b010, 2'b00, 5'd0, 1'b1); step();
    drive(mk(OP_BR,    5'd0, 5'd0, 5'd0), 1'b1); pushExp(5'b0_0_01_0, 3'b001, 2'b00, 5'd0, 1'b1); step();
    drive(mk(OP_JAL,   5'd6, 5'd0, 5'd0), 1'b1); pushExp(5'b0_0_00_1, 3'b000, 2'b01, 5'd6, 1'b1); step();
    drive(mk(OP_JALR,  5'd7, 5'd0, 5'd0), 1'b1); pushExp(5'b0_1_00_1, 3'b000, 2'b01, 5'd7, 1'b1); step();
    drive(mk(OP_LUI,   5'd8, 5'd0, 5'd0), 1'b1); pushExp(5'b0_1_11_0, 3'b000, 2'b01, 5'd8, 1'b1); step();
    drive(mk(OP_AUIPC, 5'd9, 5'd0, 5'd0), 1'b1); pushExp(5'b0_1_00_0, 3'b000, 2'b01, 5'd9, 1'b1); step();
    drive(mk(7'b0000000, 5'd0, 5'd0, 5'd0), 1'b1); pushExp(5'b1_0_00_0, 3'b000, 2'b00, 5'd0, 1'b1); step();
    idle(3, 1'b1);
  endtask

  task automatic test_load_use();
    drive(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b1);
    pushExp(5'b0_1_00_0, 3'b100, 2'b11, 5'd5, 1'b1);
    step();
    drive(mk(OP_R, 5'd6, 5'd5, 5'd7), 1'b1);
    #1;
    compared++;
    if (stall_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL hazard_stall got=%b exp=1", stall_o);
    end
    pushExp(5'b0, 3'b000, 2'b00, 5'd0, 1'b0);
    step();
    compared++;
    if (bubble_cnt_o !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL hazard_count got=%0d exp=1", bubble_cnt_o);
    end
    compared++;
    if (stall_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL hazard_stall_drop got=%b exp=0", stall_o);
    end
    pushExp(5'b0_0_10_0, 3'b000, 2'b01, 5'd6, 1'b1);
    step();
    compared++;
    if ({fwd_a_o, fwd_b_o} !== 4'b01_00) begin
      mismatched++;
      $display("[TB] FAIL hazard_fwd got=%b/%b exp=01/00", fwd_a_o, fwd_b_o);
    end
  endtask

  task automatic test_x0_load();
    drive(mk(OP_LOAD, 5'd0, 5'd1, 5'd0), 1'b1);
    pushExp(5'b0_1_00_0, 3'b100, 2'b11, 5'd0, 1'b1);
    step();
    drive(mk(OP_R, 5'd6, 5'd0, 5'd0), 1'b1);
    #1;
    compared++;
    if (stall_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL x0_stall got=%b exp=0", stall_o);
    end
    pushExp(5'b0_0_10_0, 3'b000, 2'b01, 5'd6, 1'b1);
    step();
    compared++;
    if ({fwd_a_o, fwd_b_o, bubble_cnt_o} !== 6'b00_00_01) begin
      mismatched++;
      $display("[TB] FAIL x0_fwd_cnt got=%b/%b/%0d exp=00/00/1", fwd_a_o, fwd_b_o, bubble_cnt_o);
    end
  endtask

  task automatic test_forwarding();
    drive(mk(OP_R, 5'd3, 5'd1, 5'd2), 1'b1); pushExp(5'b0_0_10_0, 3'b000, 2'b01, 5'd3, 1'b1); step();
    drive(mk(OP_R, 5'd4, 5'd3, 5'd3), 1'b1); pushExp(5'b0_0_10_0, 3'b000, 2'b01, 5'd4, 1'b1); step();
    compared++;
    if ({fwd_a_o, fwd_b_o} !== 4'b10_10) begin
      mismatched++;
      $display("[TB] FAIL fwd_exmem got=%b/%b exp=10/10", fwd_a_o, fwd_b_o);
    end
    drive(mk(OP_R, 5'd3, 5'd1, 5'd2), 1'b1);   pushExp(5'b0_0_10_0, 3'b000, 2'b01, 5'd3, 1'b1); step();
    drive(mk(OP_IMM, 5'd8, 5'd9, 5'd0), 1'b1); pushExp(5'b0_1_10_0, 3'b000, 2'b01, 5'd8, 1'b1); step();
    drive(mk(OP_R, 5'd4, 5'd3, 5'd3), 1'b1);   pushExp(5'b0_0_10_0, 3'b000, 2'b01, 5'd4, 1'b1); step();
    compared++;
    if ({fwd_a_o, fwd_b_o} !== 4'b01_01) begin
      mismatched++;
      $display("[TB] FAIL fwd_memwb got=%b/%b exp=01/01", fwd_a_o, fwd_b_o);
    end
    drive(mk(OP_R, 5'd3, 5'd1, 5'd2), 1'b1);   pushExp(5'b0_0_10_0, 3'b000, 2'b01, 5'd3, 1'b1); step();
    drive(mk(OP_IMM, 5'd3, 5'd0, 5'd0), 1'b1); pushExp(5'b0_1_10_0, 3'b000, 2'b01, 5'd3, 1'b1); step();
    drive(mk(OP_R, 5'd4, 5'd3, 5'd5), 1'b1);   pushExp(5'b0_0_10_0, 3'b000, 2'b01, 5'd4, 1'b1); step();
    compared++;
    if ({fwd_a_o, fwd_b_o} !== 4'b10_00) begin
      mismatched++;
      $display("[TB] FAIL fwd_priority got=%b/%b exp=10/00", fwd_a_o, fwd_b_o);
    end
    idle(3, 1'b1);
  endtask

  task automatic test_freeze();
    drive(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b1);
    step();
    drive(mk(OP_R, 5'd6, 5'd5, 5'd7), 1'b1);
    freeze_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush_i = (i == 1);
      step();
      compared++;
      if ({ex_aluSrc_o, ex_ALUOp_o, mem_vector_o, bubble_cnt_o, stall_o} !== {1'b1, 2'b00, 3'b000, 2'd1, 1'b1}) begin
        mismatched++;
        $display("[TB] FAIL freeze_hold i=%0d got=%b/%b/%b/%0d/%b exp=1/00/000/1/1", i,
                 ex_aluSrc_o, ex_ALUOp_o, mem_vector_o, bubble_cnt_o, stall_o);
      end
    end
    flush_i = 1'b0;
    freeze_i = 1'b0;
    step();
    compared++;
    if ({ex_aluSrc_o, ex_ALUOp_o, mem_vector_o, bubble_cnt_o, stall_o} !== {1'b0, 2'b00, 3'b100, 2'd2, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL freeze_release got=%b/%b/%b/%0d/%b exp=0/00/100/2/0",
               ex_aluSrc_o, ex_ALUOp_o, mem_vector_o, bubble_cnt_o, stall_o);
    end
    step();
    compared++;
    if ({ex_ALUOp_o, fwd_a_o} !== 4'b10_01) begin
      mismatched++;
      $display("[TB] FAIL freeze_consumer got=%b/%b exp=10/01", ex_ALUOp_o, fwd_a_o);
    end
    idle(3, 1'b0);
  endtask

  task automatic test_flush_hazard();
    drive(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b1);
    step();
    drive(mk(OP_R, 5'd6, 5'd5, 5'd7), 1'b1);
    flush_i = 1'b1;
    #1;
    compared++;
    if (stall_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_stall got=%b exp=1", stall_o);
    end
    step();
    flush_i = 1'b0;
    compared++;
    if ({ex_aluSrc_o, ex_ALUOp_o, bubble_cnt_o} !== {1'b0, 2'b00, 2'd2}) begin
      mismatched++;
      $display("[TB] FAIL flush_count got=%b/%b/%0d exp=0/00/2", ex_aluSrc_o, ex_ALUOp_o, bubble_cnt_o);
    end
    idle(3, 1'b0);
  endtask

  task automatic test_saturate();
    logic [1:0] want;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b1);
      step();
      drive(mk(OP_R, 5'd6, 5'd5, 5'd7), 1'b1);
      step();
      want = (k > 3) ? 2'd3 : 2'(k);
      compared++;
      if (bubble_cnt_o !== want) begin
        mismatched++;
        $display("[TB] FAIL saturate k=%0d got=%0d exp=%0d", k, bubble_cnt_o, want);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    drive(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b1);
    step();
    drive(mk(OP_R, 5'd6, 5'd5, 5'd7), 1'b1);
    freeze_i = 1'b1;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    freeze_i = 1'b0;
    #1;
    compared++;
    if ({illegal_o, ex_aluSrc_o, ex_ALUOp_o, ex_jump_o, fwd_a_o, fwd_b_o,
         mem_vector_o, wb_vector_o, wb_rd_o, stall_o, bubble_cnt_o} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid got=%b/%b/%b/%b/%0d/%b/%0d exp=all zero", ex_aluSrc_o, ex_ALUOp_o,
               mem_vector_o, wb_vector_o, wb_rd_o, stall_o, bubble_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_x0_load();
    test_forwarding();
    test_freeze();
    test_flush_hazard();
    test_saturate();
    test_reset_mid();
    compared++;
    if (exQ.size() + memQ.size() + wbQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending exp=0", exQ.size() + memQ.size() + wbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
